// File: rtl/hatch_if.sv
// hatch_if: button/sensor inputs and display outputs of the hatch controller.
interface hatch_if;
   logic       start_btn;
   logic       pause_btn;
   logic       temp_in;
   logic [3:0] num;
   logic       st;
   logic       temp;
   logic       done;

   modport master (output start_btn, pause_btn, temp_in,
                   input  num, st, temp, done);
   modport slave  (input  start_btn, pause_btn, temp_in,
                   output num, st, temp, done);
endinterface

// File: rtl/hatch_ctrl.sv
// hatch_ctrl: staged hatch timer with start/clear, pause/resume and over-temperature hold.
// Define HATCH_DEBOUNCE_EN to require 20 stable cycles on each button before edge detection.
module hatch_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned SEC_PER_STAGE = 5,
   parameter logic [3:0]  LAST_STAGE    = 4'd11
) (
   input logic    clk,
   input logic    rst,
   hatch_if.slave bus
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned SW = (SEC_PER_STAGE > 1) ? $clog2(SEC_PER_STAGE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_STAGE - 1);

   typedef enum logic [2:0] {IDLE, RUN, PAUSE, ALARM, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] sec_q, sec_d;
   logic [3:0]    num_q, num_d;
   logic          st_q, temp_q, done_q;

   logic [1:0] start_sync, pause_sync, temp_sync;
   logic [1:0] warm;
   logic       start_arm, pause_arm;
   logic       start_prev, pause_prev;
   logic       start_lvl_c, pause_lvl_c;
   logic       start_press_c, pause_press_c;

   // Synchronizers; warm marks when sync stage 2 holds a real post-reset sample,
   // and a button only arms after it has been seen low, so a held button never presses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_sync <= '0;
         pause_sync <= '0;
         temp_sync  <= '0;
         warm       <= '0;
         start_arm  <= 1'b0;
         pause_arm  <= 1'b0;
         start_prev <= 1'b0;
         pause_prev <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], bus.start_btn};
         pause_sync <= {pause_sync[0], bus.pause_btn};
         temp_sync  <= {temp_sync[0], bus.temp_in};
         warm       <= {warm[0], 1'b1};
         start_arm  <= start_arm | (warm[1] & ~start_sync[1]);
         pause_arm  <= pause_arm | (warm[1] & ~pause_sync[1]);
         start_prev <= start_lvl_c;
         pause_prev <= pause_lvl_c;
      end
   end

`ifdef HATCH_DEBOUNCE_EN
   localparam int unsigned DBW     = 5;
   localparam logic [DBW-1:0] DB_LAST = DBW'(19);

   logic           start_db, pause_db;
   logic [DBW-1:0] start_cnt, pause_cnt;

   // Filtered level flips only after 20 consecutive samples disagree with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_db  <= 1'b0;
         pause_db  <= 1'b0;
         start_cnt <= '0;
         pause_cnt <= '0;
      end else begin
         if (start_sync[1] == start_db) begin
            start_cnt <= '0;
         end else if (start_cnt == DB_LAST) begin
            start_db  <= start_sync[1];
            start_cnt <= '0;
         end else begin
            start_cnt <= start_cnt + DBW'(1);
         end
         if (pause_sync[1] == pause_db) begin
            pause_cnt <= '0;
         end else if (pause_cnt == DB_LAST) begin
            pause_db  <= pause_sync[1];
            pause_cnt <= '0;
         end else begin
            pause_cnt <= pause_cnt + DBW'(1);
         end
      end
   end

   assign start_lvl_c = start_db;
   assign pause_lvl_c = pause_db;
`else
   assign start_lvl_c = start_sync[1];
   assign pause_lvl_c = pause_sync[1];
`endif

   assign start_press_c = start_lvl_c & ~start_prev & start_arm;
   assign pause_press_c = pause_lvl_c & ~pause_prev & pause_arm;

   // Next-state logic; RUN counts on every edge, including the one that leaves RUN.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      sec_d   = sec_q;
      num_d   = num_q;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            sec_d   = '0;
            num_d   = '0;
            if (start_press_c) state_d = RUN;
         end
         RUN: begin
            if (presc_q == PRE_LAST) begin
               presc_d = '0;
               if (sec_q == SEC_LAST) begin
                  sec_d = '0;
                  num_d = num_q + 4'd1;
               end else begin
                  sec_d = sec_q + SW'(1);
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (num_d == LAST_STAGE)  state_d = DONE;
            else if (temp_sync[1])    state_d = ALARM;
            else if (pause_press_c)   state_d = PAUSE;
         end
         PAUSE: if (pause_press_c) state_d = RUN;
         ALARM: if (!temp_sync[1]) state_d = RUN;
         DONE: begin
            if (start_press_c) begin
               state_d = IDLE;
               num_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         sec_q   <= '0;
         num_q   <= '0;
         st_q    <= 1'b0;
         temp_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sec_q   <= sec_d;
         num_q   <= num_d;
         st_q    <= (state_d != IDLE);
         temp_q  <= (state_d != IDLE) & temp_sync[1];
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.num  = num_q;
   assign bus.st   = st_q;
   assign bus.temp = temp_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// tb_hatch_ctrl: directed and randomized checks of hatch_ctrl against a behavioural model.
module tb_hatch_ctrl;
   localparam int TPS   = 4;
   localparam int SPS   = 2;
   localparam int LAST  = 11;
   localparam int STAGE = TPS * SPS;
   localparam int DB_N  = 20;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3, M_DONE = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   hatch_if ifc ();

   hatch_ctrl #(.TICKS_PER_SEC(TPS), .SEC_PER_STAGE(SPS), .LAST_STAGE(4'(LAST)))
      dut (.clk(clk), .rst(rst), .bus(ifc));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   // Model: mode, elapsed cycles in current stage, stage number, and input histories
   // (2 = reset fill, no real sample yet).
   int m_mode, m_num, m_ph;
   int m_h [2][3];
   int m_t [2];
   bit m_pend [2];
   bit m_arm [2];
   bit m_fl [2];
   int m_run [2];
   int e_num, e_st, e_temp, e_done;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mode = M_IDLE; m_num = 0; m_ph = 0;
      e_num = 0; e_st = 0; e_temp = 0; e_done = 0;
      m_t = '{0, 0};
      for (int b = 0; b < 2; b++) begin
         m_h[b] = '{2, 2, 2};
         m_pend[b] = 1'b0; m_arm[b] = 1'b0; m_fl[b] = 1'b0; m_run[b] = 0;
      end
   endtask

   task automatic m_step();
      bit tt;
      tt = (m_t[1] != 0);
      case (m_mode)
         M_IDLE: if (m_pend[0]) begin m_mode = M_RUN; m_ph = 0; m_num = 0; end
         M_RUN: begin
            m_ph++;
            if (m_ph == STAGE) begin m_ph = 0; m_num++; end
            if (m_num == LAST) m_mode = M_DONE;
            else if (tt) m_mode = M_ALARM;
            else if (m_pend[1]) m_mode = M_PAUSE;
         end
         M_PAUSE: if (m_pend[1]) m_mode = M_RUN;
         M_ALARM: if (!tt) m_mode = M_RUN;
         default: if (m_pend[0]) begin m_mode = M_IDLE; m_num = 0; end
      endcase
      e_st   = (m_mode != M_IDLE) ? 1 : 0;
      e_done = (m_mode == M_DONE) ? 1 : 0;
      e_num  = m_num;
      e_temp = (e_st != 0 && tt) ? 1 : 0;
      m_t[1] = m_t[0];
      m_t[0] = int'(ifc.temp_in);
      for (int b = 0; b < 2; b++) begin
         m_h[b][2] = m_h[b][1];
         m_h[b][1] = m_h[b][0];
         m_h[b][0] = (b == 0) ? int'(ifc.start_btn) : int'(ifc.pause_btn);
`ifdef HATCH_DEBOUNCE_EN
         m_pend[b] = 1'b0;
         if (m_h[b][2] == 0) m_arm[b] = 1'b1;
         if ((m_h[b][2] == 1) != m_fl[b]) begin
            m_run[b]++;
            if (m_run[b] == DB_N) begin
               m_fl[b]   = (m_h[b][2] == 1);
               m_run[b]  = 0;
               m_pend[b] = m_fl[b] && m_arm[b];
            end
         end else begin
            m_run[b] = 0;
         end
`else
         m_pend[b] = (m_h[b][1] == 1) && (m_h[b][2] == 0);
`endif
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else m_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("num",  int'(ifc.num),  e_num);
         chk("st",   int'(ifc.st),   e_st);
         chk("temp", int'(ifc.temp), e_temp);
         chk("done", int'(ifc.done), e_done);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_num(input int n);
      for (int i = 0; i < 400; i++) begin
         if (int'(ifc.num) == n) break;
         tick();
      end
      chk("wait_num", int'(ifc.num), n);
   endtask

   initial begin
      ifc.start_btn = 1'b0;
      ifc.pause_btn = 1'b0;
      ifc.temp_in   = 1'b0;
      #1 rst = 1'b1;
      repeat (3) tick();
      cmp_en = 1'b1;
      chk("rst_num", int'(ifc.num), 0);
      chk("rst_st", int'(ifc.st), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_temp", int'(ifc.temp), 0);
      #2 rst = 1'b0;
      repeat (5) tick();

`ifndef HATCH_DEBOUNCE_EN
      // Press latency and uninterrupted run to completion.
      ifc.start_btn = 1'b1;
      repeat (2) tick();
      chk("lat_early", int'(ifc.st), 0);
      tick();
      chk("lat_st", int'(ifc.st), 1);
      ifc.start_btn = 1'b0;
      repeat (87) tick();
      chk("run87_num", int'(ifc.num), 10);
      chk("run87_done", int'(ifc.done), 0);
      tick();
      chk("run88_num", int'(ifc.num), 11);
      chk("run88_done", int'(ifc.done), 1);
      repeat (10) tick();
      chk("done_hold", int'(ifc.num), 11);
      ifc.start_btn = 1'b1;
      repeat (3) tick();
      chk("clr_st", int'(ifc.st), 0);
      chk("clr_num", int'(ifc.num), 0);
      chk("clr_done", int'(ifc.done), 0);
      ifc.start_btn = 1'b0;
      repeat (3) tick();

      // Pause mid-stage at 3, then resume from frozen counters.
      ifc.start_btn = 1'b1;
      repeat (3) tick();
      ifc.start_btn = 1'b0;
      wait_num(3);
      repeat (3) tick();
      ifc.pause_btn = 1'b1;
      repeat (3) tick();
      ifc.pause_btn = 1'b0;
      repeat (20) tick();
      chk("pause_num", int'(ifc.num), 3);
      chk("pause_st", int'(ifc.st), 1);
      ifc.pause_btn = 1'b1;
      repeat (3) tick();
      ifc.pause_btn = 1'b0;
      chk("resume_r0", int'(ifc.num), 3);
      tick();
      chk("resume_r1", int'(ifc.num), 3);
      tick();
      chk("resume_r2", int'(ifc.num), 4);

      // Over-temperature hold at stage 5.
      wait_num(5);
      repeat (2) tick();
      ifc.temp_in = 1'b1;
      repeat (15) tick();
      chk("alarm_temp", int'(ifc.temp), 1);
      chk("alarm_num", int'(ifc.num), 5);
      chk("alarm_st", int'(ifc.st), 1);
      ifc.temp_in = 1'b0;
      repeat (6) tick();
      chk("alarm_clear", int'(ifc.temp), 0);
      chk("alarm_resume", int'(ifc.num), 6);

      // Temperature and pause press together: alarm wins, press is dropped.
      ifc.temp_in = 1'b1;
      ifc.pause_btn = 1'b1;
      repeat (3) tick();
      ifc.pause_btn = 1'b0;
      repeat (7) tick();
      ifc.temp_in = 1'b0;
      repeat (8) tick();
      chk("tie_num", int'(ifc.num), 7);
      chk("tie_st", int'(ifc.st), 1);

      // Asynchronous reset mid-stage, with start held across its release.
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_num", int'(ifc.num), 0);
      chk("arst_st", int'(ifc.st), 0);
      ifc.start_btn = 1'b1;
      repeat (2) tick();
      #2 rst = 1'b0;
      repeat (10) tick();
      chk("held_no_press", int'(ifc.st), 0);
      ifc.start_btn = 1'b0;
      repeat (4) tick();
      ifc.start_btn = 1'b1;
      repeat (3) tick();
      chk("press_after_rel", int'(ifc.st), 1);
      ifc.start_btn = 1'b0;
`else
      // Short glitch is filtered out; a sustained press lands after 23 edges.
      ifc.start_btn = 1'b1;
      repeat (10) tick();
      ifc.start_btn = 1'b0;
      repeat (30) tick();
      chk("db_glitch", int'(ifc.st), 0);
      ifc.start_btn = 1'b1;
      repeat (22) tick();
      chk("db_early", int'(ifc.st), 0);
      tick();
      chk("db_lat", int'(ifc.st), 1);
      repeat (5) tick();
      ifc.start_btn = 1'b0;
`endif

      // Randomized traffic, including occasional resets.
      for (int c = 0; c < 4000; c++) begin
         tick();
         if ($urandom_range(0, 1499) == 0) begin
            #2 rst = 1'b1;
            tick();
            #2 rst = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) ifc.start_btn = ~ifc.start_btn;
         if ($urandom_range(0, 24) == 0) ifc.pause_btn = ~ifc.pause_btn;
         if (ifc.temp_in) begin
            if ($urandom_range(0, 14) == 0) ifc.temp_in = 1'b0;
         end else begin
            if ($urandom_range(0, 119) == 0) ifc.temp_in = 1'b1;
         end
      end
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hatch_ctrl.md
HATCH_CTRL -- requirements
Module: hatch_ctrl

Interface
REQ-001 SHALL provide parameter TICKS_PER_SEC, default 1000, clk cycles per second (clk is 1 kHz).
REQ-002 SHALL provide parameter SEC_PER_STAGE, default 5, seconds per hatch stage.
REQ-003 SHALL provide parameter LAST_STAGE, default 11, final stage index (4-bit).
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset rst, asynchronous, active-high.
REQ-006 SHALL have port start_btn  input  1  asynchronous start/clear button, active-high.
REQ-007 SHALL have port pause_btn  input  1  asynchronous pause/resume button, active-high.
REQ-008 SHALL have port temp_in  input  1  asynchronous over-temperature flag, active-high.
REQ-009 SHALL have port num  output  4  current hatch stage to display, 0..LAST_STAGE.
REQ-010 SHALL have port st  output  1  display enable; 0 blanks and clears display.
REQ-011 SHALL have port temp  output  1  temperature-alarm indication to display (red overlay).
REQ-012 SHALL have port done  output  1  hatching complete.

Function
REQ-013 SHALL pass start_btn, pause_btn, temp_in through 2-FF synchronizers; buttons SHALL be rising-edge detected into one-cycle press pulses.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, ALARM, DONE; all outputs registered.
REQ-015 IDLE: st=0, num=0, done=0, prescaler and second counter cleared; start press -> RUN.
REQ-016 RUN: st=1; prescaler counts 0..TICKS_PER_SEC-1 and wraps; on wrap second counter counts 0..SEC_PER_STAGE-1 and wraps.
REQ-017 On the edge where both counters are at terminal value, num SHALL increment by 1 (stage period = TICKS_PER_SEC*SEC_PER_STAGE cycles).
REQ-018 When the increment takes num to LAST_STAGE, FSM SHALL enter DONE on the same edge; num SHALL never exceed LAST_STAGE.
REQ-019 RUN: pause press -> PAUSE; synchronized temp_in=1 -> ALARM.
REQ-020 PAUSE: st=1, counters and num frozen; pause press -> RUN, resuming from frozen counter values.
REQ-021 ALARM: st=1, counters and num frozen; synchronized temp_in=0 -> RUN; button presses ignored.
REQ-022 DONE: st=1, done=1, num=LAST_STAGE held; start press -> IDLE.
REQ-023 start press in RUN, PAUSE, ALARM SHALL be ignored; pause press in IDLE, ALARM, DONE SHALL be ignored.
REQ-024 temp SHALL equal synchronized temp_in registered while st=1, and 0 while st=0.
REQ-025 Simultaneous temp_in=1 and pause press in RUN: ALARM wins, press discarded.
REQ-026 Simultaneous counter terminal and pause press in RUN: num increments, then PAUSE.
REQ-027 Button press SHALL change state 3 clk edges after the input rises (2 sync + 1 state).

Reset
REQ-028 rst=1 SHALL immediately force IDLE, num=0, st=0, temp=0, done=0, counters=0, synchronizers and edge detectors=0, in any state including mid-stage.
REQ-029 A button held high across rst deassertion SHALL NOT generate a press.

Configuration
REQ-030 Macro HATCH_DEBOUNCE_EN defined: each synchronized button SHALL be accepted only after stable for 20 consecutive clk cycles before edge detection (press latency 23 edges).
REQ-031 HATCH_DEBOUNCE_EN undefined: no debounce logic; synchronizer + edge detect only per REQ-013/027.

Verification (TICKS_PER_SEC=4, SEC_PER_STAGE=2, LAST_STAGE=11, HATCH_DEBOUNCE_EN undefined unless stated)
REQ-032 Start press, run undisturbed -> num steps 0,1,..,11 every 8 cycles; done=1 at 88th cycle after entering RUN; num held 11.
REQ-033 Pause press at num=3 mid-stage, hold 20 cycles, pause press -> num stays 3 while paused; stage completes after remaining cycles only.
REQ-034 temp_in=1 at num=5 for 15 cycles -> temp=1, num frozen at 5, st=1; temp_in=0 -> resume RUN, temp=0.
REQ-035 temp_in=1 and pause press same cycle in RUN -> ALARM, no PAUSE after temp clears; rst at num=7 -> num=0, st=0 immediately.
REQ-036 In DONE, start press -> IDLE, st=0, num=0, done=0; HATCH_DEBOUNCE_EN defined, 10-cycle button glitch -> ignored, 25-cycle press -> accepted.
